// File: rtl/bit_stream_pkg.sv
// Shared definitions for the bit-stream link: transmitter states, the default
// sync pattern (also used by the lock detector) and the line idle level.
package bit_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } tx_state_t;

    localparam int SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1001;
    localparam logic LINE_IDLE = 1'b0;

endpackage

// File: rtl/bit_stream_tx_piso.sv
// Parallel-in/serial-out shift register, MSB first. msb_next exposes the bit
// that will become the MSB after the next shift.
module bit_stream_piso
    import bit_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] load_data,
    output logic              msb,
    output logic              msb_next
);

    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shift_next[gi] = load_en  ? load_data[gi] :
                                        shift_en ? LINE_IDLE     : shift_reg[gi];
            end else begin : g_upper
                assign shift_next[gi] = load_en  ? load_data[gi]  :
                                        shift_en ? shift_reg[gi-1] : shift_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= shift_next;
        end
    end

    assign msb = shift_reg[DATA_W-1];

    generate
        if (DATA_W > 1) begin : g_next_wide
            assign msb_next = shift_reg[DATA_W-2];
        end else begin : g_next_single
            assign msb_next = LINE_IDLE;
        end
    endgenerate

endmodule

// File: rtl/bit_stream_tx.sv
// Serial frame transmitter: sync pattern, then payload MSB first, then idle gap.
// Define BIT_STREAM_TX_PARITY_EN to append an even-parity bit after the payload.
module bit_stream_tx
    import bit_stream_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                SYNC_W     = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEF,
    parameter int                GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              frame_done
);

    localparam int CNT_W = $clog2((SYNC_W > DATA_W) ? SYNC_W : DATA_W);
    localparam tx_state_t END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    tx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [3:0]        gap_reg, gap_next;
    logic              dout_reg, dout_next;
    logic              dout_en_reg, dout_en_next;
    logic              done_reg, done_next;
    logic              load_en, shift_en;
    logic              piso_msb, piso_msb_next;
    logic [SYNC_W-1:0] sync_shift;
`ifdef BIT_STREAM_TX_PARITY_EN
    logic              parity_reg;
`endif

    bit_stream_piso #(
        .DATA_W(DATA_W)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .shift_en (shift_en),
        .load_data(tx_data),
        .msb      (piso_msb),
        .msb_next (piso_msb_next)
    );

    assign tx_ready   = (state_reg == IDLE);
    assign dout       = dout_reg;
    assign dout_en    = dout_en_reg;
    assign frame_done = done_reg;

    // state_reg names the bit currently on dout; the dout/dout_en/frame_done
    // registers are loaded with the values belonging to state_next.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        gap_next     = gap_reg;
        load_en      = 1'b0;
        shift_en     = 1'b0;
        dout_next    = LINE_IDLE;
        dout_en_next = 1'b0;
        done_next    = 1'b0;
        sync_shift   = '0;

        case (state_reg)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    load_en    = 1'b1;
                    state_next = SYNC;
                    cnt_next   = CNT_W'(SYNC_W - 1);
                end
            end
            SYNC: begin
                if (cnt_reg == '0) begin
                    state_next = DATA;
                    cnt_next   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
`ifdef BIT_STREAM_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = END_STATE;
                    gap_next   = GAP_LOAD;
`endif
                end else begin
                    shift_en = 1'b1;
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
`ifdef BIT_STREAM_TX_PARITY_EN
            PARITY: begin
                state_next = END_STATE;
                gap_next   = GAP_LOAD;
            end
`endif
            GAP: begin
                if (gap_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        sync_shift = SYNC_PAT >> cnt_next;

        case (state_next)
            SYNC: begin
                dout_next    = sync_shift[0];
                dout_en_next = 1'b1;
            end
            DATA: begin
                // On entry from SYNC the MSB is still unshifted.
                dout_next    = (state_reg == DATA) ? piso_msb_next : piso_msb;
                dout_en_next = 1'b1;
`ifndef BIT_STREAM_TX_PARITY_EN
                done_next    = (cnt_next == '0);
`endif
            end
`ifdef BIT_STREAM_TX_PARITY_EN
            PARITY: begin
                dout_next    = parity_reg;
                dout_en_next = 1'b1;
                done_next    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            gap_reg     <= 4'd0;
            dout_reg    <= LINE_IDLE;
            dout_en_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            gap_reg     <= gap_next;
            dout_reg    <= dout_next;
            dout_en_reg <= dout_en_next;
            done_reg    <= done_next;
        end
    end

`ifdef BIT_STREAM_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (load_en) begin
            parity_reg <= ^tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx; frame patterns are hand-computed and
// follow BIT_STREAM_TX_PARITY_EN when it is defined.
module tb_bit_stream_tx;

    localparam int GAP = 2;
`ifdef BIT_STREAM_TX_PARITY_EN
    localparam int FRAME_LEN = 13;
    localparam logic [15:0] FR_A5 = 16'b000_1001_1010_0101_0;
    localparam logic [15:0] FR_3C = 16'b000_1001_0011_1100_0;
    localparam logic [15:0] FR_C3 = 16'b000_1001_1100_0011_0;
    localparam logic [15:0] FR_5A = 16'b000_1001_0101_1010_0;
    localparam logic [15:0] FR_01 = 16'b000_1001_0000_0001_1;
`else
    localparam int FRAME_LEN = 12;
    localparam logic [15:0] FR_A5 = 16'b0000_1001_1010_0101;
    localparam logic [15:0] FR_3C = 16'b0000_1001_0011_1100;
    localparam logic [15:0] FR_C3 = 16'b0000_1001_1100_0011;
    localparam logic [15:0] FR_5A = 16'b0000_1001_0101_1010;
    localparam logic [15:0] FR_01 = 16'b0000_1001_0000_0001;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       dout;
    logic       dout_en;
    logic       frame_done;

    int n_compared   = 0;
    int n_mismatched = 0;

    bit_stream_tx #(
        .DATA_W    (8),
        .SYNC_W    (4),
        .SYNC_PAT  (4'b1001),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dout      (dout),
        .dout_en   (dout_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed vector is {dout, dout_en, frame_done, tx_ready}.
    task automatic check_frame(input logic [15:0] bits, input string tag);
        logic exp_bit;
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            exp_bit = bits[FRAME_LEN-1-i];
            check_eq($sformatf("%s bit%0d", tag, i),
                     {28'd0, dout, dout_en, frame_done, tx_ready},
                     {28'd0, exp_bit, 1'b1, (i == FRAME_LEN-1), 1'b0});
        end
    endtask

    // GAP cycles with tx_ready low, then one IDLE cycle with tx_ready high.
    task automatic check_gap(input string tag);
        for (int g = 0; g <= GAP; g++) begin
            @(negedge clk);
            check_eq($sformatf("%s gap%0d", tag, g),
                     {28'd0, dout, dout_en, frame_done, tx_ready},
                     {28'd0, 1'b0, 1'b0, 1'b0, (g == GAP)});
        end
    endtask

    task automatic send_word(input logic [7:0] data, input logic [15:0] bits, input string tag);
        @(negedge clk);
        tx_data  = data;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~data;
        check_frame(bits, tag);
        check_gap(tag);
        $display("frame %s (data %02h) checked", tag, data);
    endtask

    initial begin
        logic [15:0] bits_5a;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("reset", {28'd0, dout, dout_en, frame_done, tx_ready}, 32'h1);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq($sformatf("idle%0d", i), {28'd0, dout, dout_en, frame_done, tx_ready}, 32'h1);
        end
        $display("idle period checked");

        send_word(8'hA5, FR_A5, "A5");
        send_word(8'h01, FR_01, "01");

        // tx_valid held high across two frames; C3 waits for tx_ready.
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hC3;
        check_frame(FR_3C, "3C");
        check_gap("3C");
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check_frame(FR_C3, "C3");
        check_gap("C3");
        $display("back-to-back frames 3C/C3 checked");

        // Reset asserted during the 6th bit of a frame.
        bits_5a = FR_5A;
        @(negedge clk);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("5A bit%0d", i),
                     {28'd0, dout, dout_en, frame_done, tx_ready},
                     {28'd0, bits_5a[FRAME_LEN-1-i], 1'b1, 1'b0, 1'b0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async reset", {28'd0, dout, dout_en, frame_done, tx_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("held reset%0d", i), {28'd0, dout, dout_en, frame_done, tx_ready}, 32'h1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("post reset%0d", i), {28'd0, dout, dout_en, frame_done, tx_ready}, 32'h1);
        end
        $display("mid-frame reset checked");

        send_word(8'h01, FR_01, "01 after reset");
        send_word(8'hA5, FR_A5, "A5 again");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
